// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: recovers hex digits from a multiplexed 7-segment bus once each digit period settles
module sevenseg_scan_decoder #(
  parameter int NDIG = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [7:0]        seg,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dig_valid,
  output logic [NDIG-1:0]   bad,
  output logic              frame_done,
  output logic              err
);
  typedef enum logic [1:0] {SETTLE, CAPTURE, HOLD, BLANK} state_t;
  localparam logic [7:0] CMAX = 8'(STABLE - 1);
  localparam logic [7:0] CTRIG = 8'(STABLE - 2);
  state_t state;
  logic [NDIG+7:0] s_q, prev_q;
  logic [7:0] cnt, seg_p;
  logic [NDIG-1:0] seen, an_p, sel, seen_n;
  logic [4:0] dec;
  logic same;
  function automatic logic [4:0] decode(input logic [7:0] s);
    case (s)
      8'hFC: return 5'h10;
      8'h60: return 5'h11;
      8'hDA: return 5'h12;
      8'hF2: return 5'h13;
      8'h66: return 5'h14;
      8'hB6: return 5'h15;
      8'hBE: return 5'h16;
      8'hE0: return 5'h17;
      8'hFE: return 5'h18;
      8'hF6: return 5'h19;
      8'hEE: return 5'h1A;
      8'hFF: return 5'h1B;
      8'h9C: return 5'h1C;
      8'hFD: return 5'h1D;
      8'h9E: return 5'h1E;
      8'h8E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction
  assign same = s_q == prev_q;
  // prev_q still holds the settled value during CAPTURE even if the bus has just moved on
  assign {an_p, seg_p} = prev_q;
  assign sel = ~an_p;
  assign dec = decode(seg_p);
  assign seen_n = seen | sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '1;
      prev_q <= '1;
      cnt <= '0;
      seen <= '0;
      state <= SETTLE;
      digits <= '0;
      dig_valid <= '0;
      bad <= '0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      s_q <= {an, seg};
      prev_q <= s_q;
      cnt <= !same ? 8'd0 : cnt == CMAX ? cnt : cnt + 8'd1;
      frame_done <= 1'b0;
      err <= 1'b0;
      if (state == CAPTURE) begin
        if ($onehot(sel)) begin
          for (int i = 0; i < NDIG; i++)
            if (sel[i]) begin
              if (dec[4]) begin
                digits[4*i +: 4] <= dec[3:0];
                dig_valid[i] <= 1'b1;
                bad[i] <= 1'b0;
              end else bad[i] <= 1'b1;
            end
          frame_done <= &seen_n;
          seen <= &seen_n ? '0 : seen_n;
        end else err <= 1'b1;
      end
      state <= !same ? SETTLE :
               state == CAPTURE ? HOLD :
               (state == SETTLE && cnt == CTRIG) ? (&an_p ? BLANK : CAPTURE) : state;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder: randomized and directed checks against a run-length reference model
module tb_sevenseg_scan_decoder;
  localparam int NDIG = 4;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] an = '1;
  logic [7:0] seg = '1;
  logic [15:0] digits;
  logic [3:0] dig_valid, bad;
  logic frame_done, err;
  logic [25:0] act;
  typedef struct {int due; logic [11:0] v;} ev_t;
  ev_t q[$];
  logic [7:0] codes [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'hFF, 8'h9C, 8'hFD, 8'h9E, 8'h8E};
  logic [3:0] m_dig [NDIG];
  logic [3:0] m_val, m_bad, m_seen;
  logic m_fd, m_err;
  logic [11:0] last;
  int run, cyc, total, nbad;

  always #5 clk = ~clk;

  sevenseg_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .digits(digits),
    .dig_valid(dig_valid), .bad(bad), .frame_done(frame_done), .err(err)
  );

  assign act = {digits, dig_valid, bad, frame_done, err};

  function automatic logic [25:0] exp_vec();
    logic [15:0] d;
    for (int i = 0; i < NDIG; i++) d[4*i +: 4] = m_dig[i];
    return {d, m_val, m_bad, m_fd, m_err};
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NDIG; i++) m_dig[i] = '0;
    m_val = '0; m_bad = '0; m_seen = '0; m_fd = 0; m_err = 0;
    last = '1; run = 0;
  endtask

  // A value held for STABLE samples is acted on two cycles after its STABLE-th sample
  task automatic apply(input logic [11:0] v);
    logic [3:0] a;
    int idx, n, lows;
    a = v[11:8];
    lows = $countones(~a);
    idx = 0;
    n = -1;
    if (lows > 1) m_err = 1;
    else if (lows == 1) begin
      for (int i = 0; i < NDIG; i++) if (!a[i]) idx = i;
      for (int k = 0; k < 16; k++) if (codes[k] == v[7:0]) n = k;
      if (n >= 0) begin
        m_dig[idx] = 4'(n);
        m_val[idx] = 1;
        m_bad[idx] = 0;
      end else m_bad[idx] = 1;
      m_seen[idx] = 1;
      if (&m_seen) begin
        m_fd = 1;
        m_seen = '0;
      end
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] s);
    logic [11:0] v;
    an = a;
    seg = s;
    @(posedge clk);
    cyc++;
    v = {a, s};
    run = (v == last) ? run + 1 : 1;
    last = v;
    if (run == STABLE) q.push_back('{cyc + 2, v});
    m_fd = 0;
    m_err = 0;
    while (q.size() > 0 && q[0].due == cyc) apply(q.pop_front().v);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    total++;
    if (act !== 26'd0) begin nbad++; $display("FAIL reset_async got=%h want=0", act); end
    @(posedge clk);
    #1;
    total++;
    if (act !== 26'd0) begin nbad++; $display("FAIL reset_hold got=%h want=0", act); end
    model_reset();
    rst = 0;
  endtask

  task automatic test_single_digit();
    for (int c = 0; c < 10; c++) begin
      step(4'hE, 8'hDA);
      total++;
      if (act !== exp_vec()) begin nbad++; $display("FAIL single cyc=%0d got=%h want=%h", c, act, exp_vec()); end
      if (c == STABLE) begin
        total++;
        if (dig_valid !== 4'b0000) begin nbad++; $display("FAIL single_early got=%b want=0000", dig_valid); end
      end
    end
    total++;
    if ({digits[3:0], dig_valid, bad} !== {4'h2, 4'b0001, 4'b0000})
      begin nbad++; $display("FAIL single_final got=%h/%b/%b want=2/0001/0000", digits[3:0], dig_valid, bad); end
  endtask

  task automatic test_scan();
    logic [7:0] pat [4] = '{8'hFC, 8'h60, 8'h8E, 8'hFF};
    int fd_cnt = 0;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 8; c++) begin
          step(~(4'b1 << d), pat[d]);
          total++;
          if (act !== exp_vec()) begin nbad++; $display("FAIL scan r=%0d d=%0d c=%0d got=%h want=%h", r, d, c, act, exp_vec()); end
          if (frame_done) fd_cnt++;
        end
    total++;
    if (digits !== 16'hBF10) begin nbad++; $display("FAIL scan_digits got=%h want=bf10", digits); end
    total++;
    if (fd_cnt != 2) begin nbad++; $display("FAIL scan_frames got=%0d want=2", fd_cnt); end
  endtask

  task automatic test_illegal();
    for (int c = 0; c < 8; c++) begin
      step(4'hD, 8'hF0);
      total++;
      if (act !== exp_vec()) begin nbad++; $display("FAIL illegal c=%0d got=%h want=%h", c, act, exp_vec()); end
    end
    total++;
    if ({bad[1], dig_valid[1], digits[7:4]} !== {1'b1, 1'b1, 4'h1})
      begin nbad++; $display("FAIL illegal_hold got=%b%b%h want=111", bad[1], dig_valid[1], digits[7:4]); end
    for (int c = 0; c < 8; c++) begin
      step(4'hD, 8'h66);
      total++;
      if (act !== exp_vec()) begin nbad++; $display("FAIL recover c=%0d got=%h want=%h", c, act, exp_vec()); end
    end
    total++;
    if ({bad[1], digits[7:4]} !== {1'b0, 4'h4}) begin nbad++; $display("FAIL recover_final got=%b%h want=04", bad[1], digits[7:4]); end
  endtask

  task automatic test_err_blank();
    int e_cnt = 0;
    int f_cnt = 0;
    logic [7:0] s = 8'($urandom);
    for (int c = 0; c < 16; c++) begin
      step(c < 8 ? 4'hC : 4'hF, c < 8 ? s : 8'hFF);
      total++;
      if (act !== exp_vec()) begin nbad++; $display("FAIL err_blank c=%0d got=%h want=%h", c, act, exp_vec()); end
      if (err) e_cnt++;
      if (frame_done) f_cnt++;
    end
    total++;
    if (e_cnt != 1 || f_cnt != 0) begin nbad++; $display("FAIL err_count got=%0d/%0d want=1/0", e_cnt, f_cnt); end
  endtask

  task automatic test_glitch_reset();
    for (int c = 0; c < 12; c++) begin
      step(4'hE, (c / 3) % 2 ? 8'h60 : 8'hFC);
      total++;
      if (act !== exp_vec()) begin nbad++; $display("FAIL glitch c=%0d got=%h want=%h", c, act, exp_vec()); end
    end
    step(4'hB, 8'hFC);
    step(4'hB, 8'hFC);
    #2;
    rst = 1;
    #1;
    total++;
    if (act !== 26'd0) begin nbad++; $display("FAIL midreset got=%h want=0", act); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    for (int c = 0; c < 7; c++) begin
      step(4'h7, 8'hB6);
      total++;
      if (act !== exp_vec()) begin nbad++; $display("FAIL post_reset c=%0d got=%h want=%h", c, act, exp_vec()); end
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [7:0] s;
    int len;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: a = 4'hF;
        1: a = 4'($urandom);
        default: a = ~(4'b1 << $urandom_range(0, 3));
      endcase
      s = $urandom_range(0, 3) != 0 ? codes[$urandom_range(0, 15)] : 8'($urandom);
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        step(a, s);
        total++;
        if (act !== exp_vec()) begin nbad++; $display("FAIL random n=%0d c=%0d got=%h want=%h", n, c, act, exp_vec()); end
      end
    end
  endtask

  initial begin
    total = 0;
    nbad = 0;
    cyc = 0;
    model_reset();
    test_reset();
    test_single_digit();
    test_scan();
    test_illegal();
    test_err_blank();
    test_glitch_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
